adc_scan_sequencer: RTL and testbench

//  Scan controller between the LTC2308 serial driver and the on-chip RAM. Every PERIOD clocks it

---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_prio_pick.sv | 28 ++
 rtl/adc_scan_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan sequencer: FSM state encoding,
// RAM record field offsets and the LTC2308 config-word builder.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_WRITE,
        ST_NEXT
    } state_t;

    // Record layout: [31:16] timestamp, [15] zero, [14:12] channel, [11:0] result
    localparam int unsigned REC_TS_LSB  = 16;
    localparam int unsigned REC_RSV_BIT = 15;
    localparam int unsigned REC_CH_LSB  = 12;
    localparam int unsigned REC_RES_LSB = 0;

    // LTC2308 config word {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, awake.
    function automatic logic [5:0] chan_to_conf(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    endfunction

endpackage

// File: rtl/adc_prio_pick.sv
// Next-set-bit finder: returns the lowest set bit of mask strictly above cur.
// Ports:
//   mask  in  8  candidate channels
//   cur   in  3  current channel
//   nxt   out 3  next enabled channel above cur (0 when none)
//   none  out 1  no set bit above cur
module adc_prio_pick
    import adc_pkg::*;
(
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] nxt,
    output logic       none
);

    always_comb begin
        nxt  = '0;
        none = 1'b1;
        // Scan from the top down so the last hit is the lowest qualifying bit.
        for (int unsigned k = 0; k < 8; k++) begin
            if (mask[7 - k] && ((7 - k) > 32'(cur))) begin
                nxt  = 3'(7 - k);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan controller between the LTC2308 serial driver and on-chip RAM.
// Every `period` clocks it converts each enabled channel in turn and writes one
// timestamped 32-bit record into a RAM ring; a host read port shares the RAM
// address with writes, writes having priority.
// Ports:
//   clock, rst            system clock, synchronous active-high reset
//   enable                run scans (0 = finish current channel, then idle)
//   chan_mask[7:0]        enabled channels, sampled at each scan start
//   period[15:0]          clocks between scan starts (0/1 = back-to-back)
//   drv_conf[5:0]         driver config word for the current channel
//   drv_start             conversion request to the driver
//   drv_ready, drv_res    driver result-valid level and 12-bit result
//   ram_addr/data/wren    RAM port; ram_q is the combinational read data
//   rd_req, rd_addr       host read request / address
//   rd_valid, rd_data     one-clock read-valid pulse and registered data
//   wr_ptr                next write address
//   wrapped, tmo_err      sticky ring-wrapped and channel-timeout flags
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned START_CYC = 4,
    parameter int unsigned TMO       = 255
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          enable,
    input  logic [7:0]    chan_mask,
    input  logic [15:0]   period,
    output logic [5:0]    drv_conf,
    output logic          drv_start,
    input  logic          drv_ready,
    input  logic [11:0]   drv_res,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_data,
    output logic          ram_wren,
    input  logic [31:0]   ram_q,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic [AW-1:0] wr_ptr,
    output logic          wrapped,
    output logic          tmo_err
);

    state_t        state, state_nx;
    logic [15:0]   ts;
    logic [15:0]   per_cnt;
    logic          tick;
    logic [15:0]   dwell;
    logic [7:0]    snap;
    logic [2:0]    ch;
    logic [31:0]   rec;
    logic          tmo_hit;
    logic          rd_serve;

    logic [2:0]    first_nxt, next_ch, first_ch;
    logic          first_none, next_none, scan_ok;

    // Lowest set bit of the live mask: bit 0, else the next set bit above 0.
    adc_prio_pick u_first (
        .mask (chan_mask),
        .cur  (3'd0),
        .nxt  (first_nxt),
        .none (first_none)
    );

    adc_prio_pick u_next (
        .mask (snap),
        .cur  (ch),
        .nxt  (next_ch),
        .none (next_none)
    );

    assign first_ch = chan_mask[0] ? 3'd0 : first_nxt;
    assign scan_ok  = chan_mask[0] | ~first_none;
    assign tick     = enable && ((period <= 16'd1) || (per_cnt >= period - 16'd1));
    assign rd_serve = rd_req && (state != ST_WRITE) && !rd_valid;

    always_ff @(posedge clock) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tmo_hit   = 1'b0;
        drv_start = 1'b0;
        drv_conf  = '0;
        ram_wren  = 1'b0;
        ram_addr  = rd_addr;
        ram_data  = rec;
        case (state)
            ST_IDLE:
                if (enable && scan_ok) state_nx = ST_WAIT_TICK;
            ST_WAIT_TICK:
                if (!enable)             state_nx = ST_IDLE;
                else if (tick && scan_ok) state_nx = ST_START;
            ST_START: begin
                drv_start = !rst;
                drv_conf  = chan_to_conf(ch);
                if (dwell == 16'(START_CYC - 1)) state_nx = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                drv_conf = chan_to_conf(ch);
                if (!drv_ready) state_nx = ST_WAIT_DONE;
                else if (dwell == 16'(TMO)) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_NEXT;
                end
            end
            ST_WAIT_DONE: begin
                drv_conf = chan_to_conf(ch);
                if (drv_ready) state_nx = ST_WRITE;
                else if (dwell == 16'(TMO)) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_NEXT;
                end
            end
            ST_WRITE: begin
                // Write owns the RAM port; any pending host read waits a clock.
                ram_wren = !rst;
                ram_addr = wr_ptr;
                state_nx = ST_NEXT;
            end
            ST_NEXT:
                if (!enable)        state_nx = ST_IDLE;
                else if (next_none) state_nx = ST_WAIT_TICK;
                else                state_nx = ST_START;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ts       <= '0;
            per_cnt  <= '0;
            dwell    <= '0;
            snap     <= '0;
            ch       <= '0;
            rec      <= '0;
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            tmo_err  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            ts      <= ts + 16'd1;
            per_cnt <= (!enable || tick) ? 16'd0 : per_cnt + 16'd1;
            // One dwell counter serves START length and both wait timeouts.
            dwell   <= (state_nx != state) ? 16'd0 : dwell + 16'd1;

            if (state == ST_WAIT_TICK && state_nx == ST_START) begin
                snap <= chan_mask;
                ch   <= first_ch;
            end
            if (state == ST_NEXT && state_nx == ST_START) ch <= next_ch;

            if (state == ST_WAIT_DONE && drv_ready) begin
                rec[REC_TS_LSB +: 16]  <= ts;
                rec[REC_RSV_BIT]       <= 1'b0;
                rec[REC_CH_LSB +: 3]   <= ch;
                rec[REC_RES_LSB +: 12] <= drv_res;
            end

            if (state == ST_WRITE) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == '1) wrapped <= 1'b1;
            end

            if (tmo_hit) tmo_err <= 1'b1;

            rd_valid <= rd_serve;
            if (rd_serve) rd_data <= ram_q;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural LTC2308 model
// and a 256 x 32 array RAM.
module tb_adc_scan_sequencer;
    import adc_pkg::*;

    localparam int unsigned AW  = 8;
    localparam int unsigned TMO = 255;

    logic          clock, rst, enable;
    logic [7:0]    chan_mask;
    logic [15:0]   period;
    logic [5:0]    drv_conf;
    logic          drv_start, drv_ready;
    logic [11:0]   drv_res;
    logic [AW-1:0] ram_addr, rd_addr, wr_ptr;
    logic [31:0]   ram_data, ram_q, rd_data;
    logic          ram_wren, rd_req, rd_valid, wrapped, tmo_err;

    int n_cmp = 0;
    int n_bad = 0;

    adc_scan_sequencer #(.AW(AW), .START_CYC(4), .TMO(TMO)) dut (
        .clock(clock), .rst(rst), .enable(enable), .chan_mask(chan_mask), .period(period),
        .drv_conf(drv_conf), .drv_start(drv_start), .drv_ready(drv_ready), .drv_res(drv_res),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_ptr(wr_ptr), .wrapped(wrapped), .tmo_err(tmo_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model
    logic [31:0] mem [0:255];
    assign ram_q = mem[ram_addr];

    // LTC2308 model: ready drops 2 clk after start, rises 30 clk later.
    logic       stuck = 1'b0;
    logic       m_busy;
    logic [7:0] m_cnt;
    logic [2:0] m_ch;
    always @(posedge clock) begin
        if (rst) begin
            m_busy <= 1'b0; m_cnt <= '0; m_ch <= '0;
            drv_ready <= 1'b1; drv_res <= '0;
        end else if (drv_start && !m_busy) begin
            m_busy <= 1'b1; m_cnt <= '0;
            m_ch   <= {drv_conf[3], drv_conf[2], drv_conf[4]};
        end else if (m_busy) begin
            m_cnt <= m_cnt + 8'd1;
            if (m_cnt == 8'd1) drv_ready <= 1'b0;
            if (m_cnt == 8'd31) begin
                m_busy <= 1'b0;
                if (!stuck) begin
                    drv_ready <= 1'b1;
                    drv_res   <= 12'h100 + {9'd0, m_ch};
                end
            end
        end
    end

    // Write / start monitor with the expected timestamp of each record
    logic [15:0]   tb_ts;
    int            cyc = 0;
    logic          start_d = 1'b0;
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    logic [15:0]   wt_q[$];
    int            st_q[$];
    logic [5:0]    sc_q[$];
    always @(posedge clock) begin
        cyc     <= cyc + 1;
        tb_ts   <= rst ? 16'd0 : tb_ts + 16'd1;
        start_d <= drv_start;
        if (ram_wren) begin
            mem[ram_addr] <= ram_data;
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_data);
            wt_q.push_back(tb_ts - 16'd1);
        end
        if (drv_start && !start_d) begin
            st_q.push_back(cyc);
            sc_q.push_back(drv_conf);
        end
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wt_q.delete(); st_q.delete(); sc_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1; enable = 1'b0; rd_req = 1'b0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_cmp++; if ({drv_start, ram_wren, rd_valid, drv_conf} !== '0) begin n_bad++;
            $display("FAIL reset_ctrl: got %0h want 0", {drv_start, ram_wren, rd_valid, drv_conf}); end
        n_cmp++; if (wr_ptr !== '0) begin n_bad++; $display("FAIL reset_wr_ptr: got %0d want 0", wr_ptr); end
        n_cmp++; if ({wrapped, tmo_err} !== 2'b00) begin n_bad++;
            $display("FAIL reset_flags: got %b want 00", {wrapped, tmo_err}); end
        n_cmp++; if (rd_data !== '0 || ram_data !== '0) begin n_bad++;
            $display("FAIL reset_data: got %0h/%0h want 0/0", rd_data, ram_data); end
        rst = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++; if (dut.state !== ST_IDLE || drv_start !== 1'b0) begin n_bad++;
            $display("FAIL reset_idle: got state %0d start %b want 0 0", dut.state, drv_start); end
    endtask

    task automatic test_scan();
        int k;
        logic [15:0] exp_lo [4];
        exp_lo[0] = 16'h0100; exp_lo[1] = 16'h2102; exp_lo[2] = 16'h0100; exp_lo[3] = 16'h2102;
        do_reset();
        chan_mask = 8'h05; period = 16'd200; enable = 1'b1;
        k = 0;
        while ((st_q.size() < 3 || wd_q.size() < 4) && k < 1000) begin @(negedge clock); k++; end
        n_cmp++; if (st_q.size() < 3 || wd_q.size() < 4) begin n_bad++;
            $display("FAIL scan_wait: got %0d starts %0d writes want 3 4", st_q.size(), wd_q.size());
            return; end
        n_cmp++; if (sc_q[0] !== 6'b100010) begin n_bad++; $display("FAIL scan_conf0: got %b want 100010", sc_q[0]); end
        n_cmp++; if (sc_q[1] !== 6'b100110) begin n_bad++; $display("FAIL scan_conf2: got %b want 100110", sc_q[1]); end
        n_cmp++; if (sc_q[2] !== 6'b100010) begin n_bad++; $display("FAIL scan_conf0b: got %b want 100010", sc_q[2]); end
        n_cmp++; if (st_q[2] - st_q[0] != 200) begin n_bad++;
            $display("FAIL scan_period: got %0d want 200", st_q[2] - st_q[0]); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (wd_q[i][15:0] !== exp_lo[i] || wa_q[i] !== AW'(i)) begin n_bad++;
                $display("FAIL scan_rec%0d: got %0h @%0d want %0h @%0d", i, wd_q[i][15:0], wa_q[i], exp_lo[i], i); end
            n_cmp++; if (wd_q[i][31:16] !== wt_q[i]) begin n_bad++;
                $display("FAIL scan_ts%0d: got %0h want %0h", i, wd_q[i][31:16], wt_q[i]); end
        end
        n_cmp++; if (wr_ptr !== 8'd4) begin n_bad++; $display("FAIL scan_wr_ptr: got %0d want 4", wr_ptr); end
        enable = 1'b0;
        repeat (100) @(negedge clock);
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        chan_mask = 8'h03; period = 16'd0; enable = 1'b1;
        k = 0;
        while (wd_q.size() < 255 && k < 12000) begin @(negedge clock); k++; end
        n_cmp++; if (wr_ptr !== 8'd255 || wrapped !== 1'b0) begin n_bad++;
            $display("FAIL wrap_pre: got ptr %0d wrapped %b want 255 0", wr_ptr, wrapped); end
        while (wd_q.size() < 256 && k < 12000) begin @(negedge clock); k++; end
        n_cmp++; if (wr_ptr !== 8'd0 || wrapped !== 1'b1) begin n_bad++;
            $display("FAIL wrap_post: got ptr %0d wrapped %b want 0 1", wr_ptr, wrapped); end
        while (wd_q.size() < 258 && k < 12000) begin @(negedge clock); k++; end
        n_cmp++; if (wd_q.size() < 258) begin n_bad++;
            $display("FAIL wrap_wait: got %0d writes want 258", wd_q.size()); return; end
        n_cmp++; if (wa_q[256] !== 8'd0 || wa_q[257] !== 8'd1) begin n_bad++;
            $display("FAIL wrap_addr: got %0d,%0d want 0,1", wa_q[256], wa_q[257]); end
        n_cmp++; if (wd_q[256][15:0] !== 16'h0100 || wd_q[257][15:0] !== 16'h1101) begin n_bad++;
            $display("FAIL wrap_data: got %0h,%0h want 100,1101", wd_q[256][15:0], wd_q[257][15:0]); end
    endtask

    task automatic test_timeout();
        int k;
        enable = 1'b0;
        k = 0;
        while (dut.state !== ST_IDLE && k < 400) begin @(negedge clock); k++; end
        stuck = 1'b1;
        clear_logs();
        n_cmp++; if (tmo_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pre: got %b want 0", tmo_err); end
        enable = 1'b1;
        k = 0;
        while (drv_start !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        k = 0;
        while (tmo_err !== 1'b1 && k < 600) begin @(negedge clock); k++; end
        n_cmp++; if (k < int'(TMO) + 5 || k > int'(TMO) + 8) begin n_bad++;
            $display("FAIL tmo_time: got %0d clocks want %0d..%0d", k, TMO + 5, TMO + 8); end
        k = 0;
        while (drv_start !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        n_cmp++; if (drv_conf !== 6'b110010) begin n_bad++;
            $display("FAIL tmo_next_ch: got %b want 110010", drv_conf); end
        enable = 1'b0;
        k = 0;
        while (dut.state !== ST_IDLE && k < 400) begin @(negedge clock); k++; end
        n_cmp++; if (wd_q.size() != 0 || tmo_err !== 1'b1) begin n_bad++;
            $display("FAIL tmo_nowrite: got %0d writes tmo %b want 0 1", wd_q.size(), tmo_err); end
    endtask

    task automatic test_rst_mid();
        int k, nw;
        logic saw_start;
        stuck = 1'b0;
        enable = 1'b1;
        k = 0;
        while (drv_start !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        repeat (20) @(negedge clock);
        n_cmp++; if (dut.state !== ST_WAIT_DONE || wrapped !== 1'b1 || tmo_err !== 1'b1) begin n_bad++;
            $display("FAIL rst_pre: got state %0d wrapped %b tmo %b want %0d 1 1", dut.state, wrapped, tmo_err, ST_WAIT_DONE); end
        nw = wd_q.size();
        rst = 1'b1; enable = 1'b0;
        @(negedge clock);
        n_cmp++; if (drv_start !== 1'b0 || ram_wren !== 1'b0) begin n_bad++;
            $display("FAIL rst_start: got start %b wren %b want 0 0", drv_start, ram_wren); end
        n_cmp++; if (wr_ptr !== '0 || wrapped !== 1'b0 || tmo_err !== 1'b0) begin n_bad++;
            $display("FAIL rst_clear: got ptr %0d wrapped %b tmo %b want 0 0 0", wr_ptr, wrapped, tmo_err); end
        rst = 1'b0;
        saw_start = 1'b0;
        repeat (60) begin @(negedge clock); if (drv_start) saw_start = 1'b1; end
        n_cmp++; if (wd_q.size() != nw || saw_start) begin n_bad++;
            $display("FAIL rst_quiet: got %0d writes start %b want %0d 0", wd_q.size(), saw_start, nw); end
    endtask

    task automatic test_read();
        int k, widx;
        logic [AW-1:0] wp;
        do_reset();
        chan_mask = 8'h05; period = 16'd0; enable = 1'b1;
        k = 0;
        while (wd_q.size() < 7 && k < 600) begin @(negedge clock); k++; end
        n_cmp++; if (wd_q.size() < 7) begin n_bad++; $display("FAIL rd_fill: got %0d writes want 7", wd_q.size()); return; end
        k = 0;
        while (ram_wren === 1'b1 && k < 10) begin @(negedge clock); k++; end
        rd_req = 1'b1; rd_addr = 8'd4;
        @(negedge clock);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== wd_q[4] || rd_data[15:0] !== 16'h0100) begin n_bad++;
            $display("FAIL rd_lat1: got valid %b data %0h want 1 %0h", rd_valid, rd_data, wd_q[4]); end
        rd_req = 1'b0;
        @(negedge clock);
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_pulse: got %b want 0", rd_valid); end
        k = 0;
        while (ram_wren !== 1'b1 && k < 100) begin @(negedge clock); k++; end
        widx = wd_q.size(); wp = wr_ptr;
        rd_req = 1'b1; rd_addr = 8'd5;
        @(negedge clock);
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_held: got valid %b want 0", rd_valid); end
        @(negedge clock);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== wd_q[5] || rd_data[15:0] !== 16'h2102) begin n_bad++;
            $display("FAIL rd_lat2: got valid %b data %0h want 1 %0h", rd_valid, rd_data, wd_q[5]); end
        rd_req = 1'b0;
        n_cmp++; if (wd_q.size() != widx + 1 || wa_q[widx] !== wp) begin n_bad++;
            $display("FAIL rd_write_kept: got %0d writes addr %0d want %0d %0d", wd_q.size(), wa_q[widx], widx + 1, wp); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int k;
        do_reset();
        chan_mask = 8'h0F; period = 16'd0; enable = 1'b1;
        k = 0;
        while (drv_start !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        repeat (10) @(negedge clock);
        n_cmp++; if (drv_conf !== 6'b100010) begin n_bad++; $display("FAIL en_conf: got %b want 100010", drv_conf); end
        enable = 1'b0;
        repeat (150) @(negedge clock);
        n_cmp++; if (wd_q.size() != 1 || st_q.size() != 1) begin n_bad++;
            $display("FAIL en_counts: got %0d writes %0d starts want 1 1", wd_q.size(), st_q.size()); return; end
        n_cmp++; if (wd_q[0][15:0] !== 16'h0100 || wa_q[0] !== 8'd0 || wr_ptr !== 8'd1) begin n_bad++;
            $display("FAIL en_rec: got %0h @%0d ptr %0d want 100 @0 1", wd_q[0][15:0], wa_q[0], wr_ptr); end
        n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL en_idle: got %0d want %0d", dut.state, ST_IDLE); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; enable = 1'b0; chan_mask = '0; period = '0;
        rd_req = 1'b0; rd_addr = '0;
        test_reset();
        test_scan();
        test_wrap();
        test_timeout();
        test_rst_mid();
        test_read();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
